joy_adc_drp_sampler: RTL and testbench
======================================

Name: joy_adc_drp_sampler

Overview:
Front-end stage that feeds the joystick AXI4-Lite register IP (myip_adc_joy). It acts as a DRP master to the XADC, reads the X and Y auxiliary channels after each end-of-conversion, and averages 2^AVG_LOG2 sample pairs. It then publishes the 12-bit X/Y values, a direction decode and a one-cycle valid strobe, which the register IP latches into its read-only slave registers.

Parameters:
ADDR_X, 7'h16, DRP address of X channel (VAUX6)
ADDR_Y, 7'h1E, DRP address of Y channel (VAUX14)
AVG_LOG2, 2, log2 of sample pairs averaged per published result (0..4)
CENTER, 12'd2048, joystick rest code
DEADBAND, 12'd100, half-width of the no-direction zone
TIMEOUT, 8'd64, max cycles from drp_den to drp_drdy

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
enable  in  1  sampling enable, driven from a register-IP control bit
eoc  in  1  XADC end-of-conversion pulse
drp_den  out  1  DRP enable, one-cycle pulse
drp_daddr  out  7  DRP address
drp_dwe  out  1  DRP write enable, tied 0
drp_drdy  in  1  DRP read data ready
drp_do  in  16  DRP read data; result is drp_do[15:4]
clr_err  in  1  clears timeout_err
joy_x  out  12  averaged X
joy_y  out  12  averaged Y
joy_dir  out  4  {up,down,left,right}
sample_valid  out  1  one-cycle pulse when joy_x/joy_y/joy_dir update
timeout_err  out  1  sticky DRP timeout flag

Behaviour:
- Reset, asynchronous and active-low, sets all outputs to 0, the FSM to IDLE, and clears the accumulators, pair counter, pending flag and timeout counter.
- FSM states: IDLE, RD_X, WAIT_X, RD_Y, WAIT_Y, PUBLISH.
- IDLE: if enable=1 and (eoc=1 or pending=1), go to RD_X and clear pending. An eoc sampled at edge n produces drp_den=1 with drp_daddr=ADDR_X in cycle n+1.
- RD_X / RD_Y: drp_den=1 for exactly one cycle, with drp_daddr held until drdy. Then go to WAIT_X / WAIT_Y and start the timeout counter.
- WAIT_X on drp_drdy: add drp_do[15:4] to acc_x and go to RD_Y (Y den in the next cycle).
- WAIT_Y on drp_drdy: add the data to acc_y and increment the pair count. If count reaches 2^AVG_LOG2, go to PUBLISH; otherwise go to IDLE.
- PUBLISH (one cycle):
  - joy_x = acc_x >> AVG_LOG2 and joy_y = acc_y >> AVG_LOG2, truncated.
  - joy_dir is registered from the new values:
    - right = x > CENTER+DEADBAND; left = x < CENTER-DEADBAND.
    - up = y > CENTER+DEADBAND; down = y < CENTER-DEADBAND.
  - Clear the accumulators and count, then go to IDLE.
  - Outputs and sample_valid are visible 2 cycles after the final Y drdy edge; sample_valid is high for 1 cycle.
- Accumulator width is 12+AVG_LOG2 bits; overflow is not possible.
- drp_den is never asserted while a DRP read is outstanding.
- Timeout: if drdy is absent for TIMEOUT cycles in WAIT_X/WAIT_Y, set timeout_err, discard the current half-pair (partial X not added to Y pair count), and go to IDLE. Previously completed pairs are kept.
- A late drdy arriving in IDLE is ignored.
- clr_err clears timeout_err; if set and clear occur in the same cycle, set wins.
- An eoc arriving while not in IDLE sets pending (single depth; extra eocs are dropped). An eoc arriving in the same cycle as the IDLE transition is consumed directly.
- Deassertion of enable:
  - An outstanding DRP read completes or times out; it is never aborted.
  - The FSM then returns to IDLE, clears the accumulators, count and pending, and does not publish.
  - Published outputs retain their last values.

Test Plan:
1. Reset: hold ARESETN=0 for 200 ns with eoc toggling -> all outputs 0, drp_den never 1, drp_dwe 0 throughout.
2. AVG_LOG2=2, 4 eocs; X data 0x8000 each; Y data 0x1000,0x2000,0x3000,0x4000 -> a single sample_valid 2 cycles after the 4th Y drdy; joy_x=2048, joy_y=640; joy_dir=4'b0100 (down).
3. Deadband boundary: all-X samples 2148 -> right=0; all-X 2149 -> right=1; all-X 1948 -> left=0; all-X 1947 -> left=1.
4. DRP timeout: drdy withheld after X den -> timeout_err=1 exactly 64 cycles after den, FSM back in IDLE; the next eoc completes normally; clr_err pulse -> timeout_err=0.
5. eoc during WAIT_Y -> pending set; RD_X den issued the cycle after returning to IDLE; a second eoc during the same busy window is dropped (only one extra X read).
6. enable dropped in WAIT_X after 3 completed pairs -> drdy consumed, no sample_valid; after re-enable, 4 new pairs are needed before the next publish, with the average computed from new data only.

Source files
------------

// File: rtl/joy_adc_drp_sampler.sv
// ---------------------------------------------------------------------------
// joy_adc_drp_sampler
//
// Purpose: DRP read master for the XADC joystick channels. Each end of
// conversion triggers a read of the X auxiliary channel and then the Y
// auxiliary channel. 2^AVG_LOG2 X/Y pairs are accumulated and averaged. The
// average, a direction decode and a one-cycle strobe are then published to
// the AXI4-Lite register IP.
//
// Ports:
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   enable          sampling enable (register-IP control bit)
//   eoc             XADC end-of-conversion pulse
//   drp_den/daddr/dwe   DRP request side (dwe is always 0)
//   drp_drdy/drp_do     DRP response side; the result is drp_do[15:4]
//   clr_err         clears the sticky timeout flag (a set in the same cycle wins)
//   joy_x/joy_y     averaged 12-bit positions
//   joy_dir         {up,down,left,right}
//   sample_valid    one-cycle strobe when joy_x/joy_y/joy_dir update
//   timeout_err     sticky DRP timeout flag
//   dbg_state       current FSM state: 0 IDLE, 1 RD_X, 2 WAIT_X, 3 RD_Y,
//                   4 WAIT_Y, 5 PUBLISH
//
// DRP handshake: drp_den is a single-cycle request strobe. drp_daddr stays
// stable from the den cycle until drp_drdy. Exactly one read is outstanding
// at a time, and no new den is issued until drdy arrives or the read times
// out. A drp_drdy that arrives while no read is outstanding is ignored.
// ---------------------------------------------------------------------------
module joy_adc_drp_sampler #(
    parameter logic [6:0]  ADDR_X   = 7'h16,
    parameter logic [6:0]  ADDR_Y   = 7'h1E,
    parameter int unsigned AVG_LOG2 = 2,
    parameter logic [11:0] CENTER   = 12'd2048,
    parameter logic [11:0] DEADBAND = 12'd100,
    parameter logic [7:0]  TIMEOUT  = 8'd64
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic        eoc,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        drp_dwe,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    input  logic        clr_err,
    output logic [11:0] joy_x,
    output logic [11:0] joy_y,
    output logic [3:0]  joy_dir,
    output logic        sample_valid,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'((1 << AVG_LOG2) - 1);
    // Thresholds are 13 bits wide so that CENTER+DEADBAND cannot wrap.
    localparam logic [12:0] HI_TH = {1'b0, CENTER} + {1'b0, DEADBAND};
    localparam logic [12:0] LO_TH = {1'b0, CENTER} - {1'b0, DEADBAND};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_X    = 3'd1,
        WAIT_X  = 3'd2,
        RD_Y    = 3'd3,
        WAIT_Y  = 3'd4,
        PUBLISH = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [ACC_W-1:0]  acc_x_q, acc_x_d;
    logic [ACC_W-1:0]  acc_y_q, acc_y_d;
    logic [11:0]       x_hold_q, x_hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              abort_q, abort_d;
    logic [11:0]       joy_x_q, joy_x_d;
    logic [11:0]       joy_y_q, joy_y_d;
    logic [3:0]        dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [11:0] rd_data;
    logic        in_wait;
    logic        tmo_hit;
    logic        start;
    logic        stop;
    logic [11:0] avg_x;
    logic [11:0] avg_y;
    logic        unused_low_bits;

    assign rd_data = drp_do[15:4];
    assign unused_low_bits = ^drp_do[3:0];

    assign in_wait = (state_q == WAIT_X) || (state_q == WAIT_Y);
    // The counter is loaded with 1 in the den cycle, so it reaches TIMEOUT-1
    // in the last cycle of a TIMEOUT-cycle window that starts at den.
    assign tmo_hit = in_wait && !drp_drdy && (tmo_q == TIMEOUT - 8'd1);
    assign start   = (state_q == IDLE) && enable && (eoc || pending_q);
    // enable may drop at any time during a read. abort_q remembers that it
    // dropped, so the read still completes but nothing is accumulated.
    assign stop    = !enable || abort_q;

    assign avg_x = acc_x_q[AVG_LOG2 +: 12];
    assign avg_y = acc_y_q[AVG_LOG2 +: 12];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_X;
            RD_X:    state_d = WAIT_X;
            WAIT_X: begin
                if (drp_drdy)     state_d = stop ? IDLE : RD_Y;
                else if (tmo_hit) state_d = IDLE;
            end
            RD_Y:    state_d = WAIT_Y;
            WAIT_Y: begin
                if (drp_drdy) begin
                    if (!stop && (cnt_q == LAST_PAIR)) state_d = PUBLISH;
                    else                               state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        drp_den   = 1'b0;
        drp_daddr = 7'd0;
        case (state_q)
            RD_X:    begin drp_den = 1'b1; drp_daddr = ADDR_X; end
            WAIT_X:  drp_daddr = ADDR_X;
            RD_Y:    begin drp_den = 1'b1; drp_daddr = ADDR_Y; end
            WAIT_Y:  drp_daddr = ADDR_Y;
            default: ;
        endcase
    end

    assign drp_dwe = 1'b0;

    // ---------------- datapath next state ----------------
    always_comb begin
        tmo_d     = 8'd0;
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        x_hold_d  = x_hold_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        abort_d   = abort_q;
        joy_x_d   = joy_x_q;
        joy_y_d   = joy_y_q;
        dir_d     = dir_q;
        valid_d   = 1'b0;
        err_d     = err_q;

        // Timeout counter covers the den cycle plus the wait cycles.
        if ((state_q == RD_X) || (state_q == RD_Y)) tmo_d = 8'd1;
        else if (in_wait)                           tmo_d = tmo_q + 8'd1;

        // Single-depth pending eoc: extra eocs while busy are dropped.
        if (state_q == IDLE) begin
            abort_d = 1'b0;
            if (start || !enable) pending_d = 1'b0;
            if (!enable) begin
                acc_x_d = '0;
                acc_y_d = '0;
                cnt_d   = '0;
            end
        end else begin
            if (eoc)     pending_d = 1'b1;
            if (!enable) abort_d   = 1'b1;
        end

        // X is parked until its Y arrives, so a timed-out half pair never
        // reaches the accumulators.
        if ((state_q == WAIT_X) && drp_drdy) x_hold_d = rd_data;

        if (in_wait && drp_drdy && stop) begin
            acc_x_d   = '0;
            acc_y_d   = '0;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if ((state_q == WAIT_Y) && drp_drdy) begin
            acc_x_d = acc_x_q + ACC_W'(x_hold_q);
            acc_y_d = acc_y_q + ACC_W'(rd_data);
            cnt_d   = cnt_q + CNT_W'(1);
        end

        if (state_q == PUBLISH) begin
            joy_x_d = avg_x;
            joy_y_d = avg_y;
            dir_d   = {({1'b0, avg_y} > HI_TH), ({1'b0, avg_y} < LO_TH),
                       ({1'b0, avg_x} < LO_TH), ({1'b0, avg_x} > HI_TH)};
            valid_d = 1'b1;
            acc_x_d = '0;
            acc_y_d = '0;
            cnt_d   = '0;
        end

        // Set has priority over clear.
        if (tmo_hit)      err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmo_q     <= 8'd0;
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            x_hold_q  <= 12'd0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            abort_q   <= 1'b0;
            joy_x_q   <= 12'd0;
            joy_y_q   <= 12'd0;
            dir_q     <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            x_hold_q  <= x_hold_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            abort_q   <= abort_d;
            joy_x_q   <= joy_x_d;
            joy_y_q   <= joy_y_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign joy_x        = joy_x_q;
    assign joy_y        = joy_y_q;
    assign joy_dir      = dir_q;
    assign sample_valid = valid_q;
    assign timeout_err  = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_joy_adc_drp_sampler.sv
// Directed bench for joy_adc_drp_sampler: a DRP responder task, a pair
// driver and publish checks, all sequenced from one initial block.
module tb_joy_adc_drp_sampler;

    localparam logic [6:0] AX = 7'h16;
    localparam logic [6:0] AY = 7'h1E;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        enable;
    logic        eoc;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_dwe;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic        clr_err;
    logic [11:0] joy_x;
    logic [11:0] joy_y;
    logic [3:0]  joy_dir;
    logic        sample_valid;
    logic        timeout_err;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [11:0] t3_x   [4] = '{12'd2148, 12'd2149, 12'd1948, 12'd1947};
    logic [3:0]  t3_dir [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010};
    logic [11:0] t2_y   [4] = '{12'h100, 12'h200, 12'h300, 12'h400};

    joy_adc_drp_sampler dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .enable       (enable),
        .eoc          (eoc),
        .drp_den      (drp_den),
        .drp_daddr    (drp_daddr),
        .drp_dwe      (drp_dwe),
        .drp_drdy     (drp_drdy),
        .drp_do       (drp_do),
        .clr_err      (clr_err),
        .joy_x        (joy_x),
        .joy_y        (joy_y),
        .joy_dir      (joy_dir),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 ACLK = ~ACLK;

    // Absolute time bound for the whole run.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check / driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge ACLK);
    endtask

    task automatic pulse_eoc();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
    endtask

    // Wait (bounded) for a den, check the address, answer after lat cycles.
    task automatic serve(input logic [6:0] addr, input logic [11:0] val, input int lat);
        int n;
        n = 0;
        while (drp_den !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("den_seen", 32'(drp_den), 32'd1);
        chk("den_addr", 32'(drp_daddr), 32'(addr));
        step();
        chk("den_one_cycle", 32'(drp_den), 32'd0);
        chk("addr_held", 32'(drp_daddr), 32'(addr));
        repeat (lat - 1) step();
        drp_do   = {val, 4'h9};
        drp_drdy = 1'b1;
        step();
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
    endtask

    task automatic do_pair(input logic [11:0] x, input logic [11:0] y);
        pulse_eoc();
        serve(AX, x, int'($urandom_range(1, 4)));
        serve(AY, y, int'($urandom_range(1, 4)));
        chk("sv_quiet", 32'(sample_valid), 32'd0);
    endtask

    // Called one cycle after the final Y drdy; the strobe is due one later.
    task automatic expect_publish(input string tag, input logic [11:0] x,
                                  input logic [11:0] y, input logic [3:0] dir);
        step();
        chk({tag, "_sv"}, 32'(sample_valid), 32'd1);
        chk({tag, "_x"}, 32'(joy_x), 32'(x));
        chk({tag, "_y"}, 32'(joy_y), 32'(y));
        chk({tag, "_dir"}, 32'(joy_dir), 32'(dir));
        step();
        chk({tag, "_sv_one"}, 32'(sample_valid), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic flag;

        ARESETN  = 1'b0;
        enable   = 1'b1;
        eoc      = 1'b0;
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        clr_err  = 1'b0;

        // 1: reset held 200 ns with eoc toggling
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            eoc = ~eoc;
            if (drp_den !== 1'b0 || drp_dwe !== 1'b0) flag = 1'b1;
        end
        chk("rst_den_dwe_quiet", 32'(flag), 32'd0);
        chk("rst_joy_x", 32'(joy_x), 32'd0);
        chk("rst_joy_y", 32'(joy_y), 32'd0);
        chk("rst_dir", 32'(joy_dir), 32'd0);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_daddr", 32'(drp_daddr), 32'd0);
        eoc = 1'b0;
        step();
        ARESETN = 1'b1;
        step();
        step();
        chk("post_rst_idle", 32'(dbg_state), 32'd0);
        chk("post_rst_no_den", 32'(drp_den), 32'd0);

        // 2: four pairs, X=2048, Y 256..1024 -> 640, down
        for (int i = 0; i < 4; i++) do_pair(12'h800, t2_y[i]);
        expect_publish("avg", 12'd2048, 12'd640, 4'b0100);

        // 3: deadband boundaries on X
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) do_pair(t3_x[k], 12'd2048);
            expect_publish("deadband", t3_x[k], 12'd2048, t3_dir[k]);
        end

        // 4a: X drdy withheld -> error 64 cycles after den
        pulse_eoc();
        chk("t4_den", 32'(drp_den), 32'd1);
        repeat (63) step();
        chk("t4_err_not_yet", 32'(timeout_err), 32'd0);
        step();
        chk("t4_err_set", 32'(timeout_err), 32'd1);
        chk("t4_back_idle", 32'(dbg_state), 32'd0);
        drp_do   = 16'hFFF0;
        drp_drdy = 1'b1;
        step();
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        chk("t4_late_drdy_idle", 32'(dbg_state), 32'd0);
        chk("t4_late_drdy_no_den", 32'(drp_den), 32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);

        // 4b: Y timeout after two full pairs; set beats a simultaneous clear
        do_pair(12'd1000, 12'd2048);
        do_pair(12'd1000, 12'd2048);
        pulse_eoc();
        serve(AX, 12'd4000, 1);
        chk("t4b_y_den", 32'(drp_den), 32'd1);
        repeat (62) step();
        clr_err = 1'b1;
        step();
        chk("t4b_err_not_yet", 32'(timeout_err), 32'd0);
        step();
        chk("t4b_set_wins", 32'(timeout_err), 32'd1);
        clr_err = 1'b0;
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t4b_err_cleared", 32'(timeout_err), 32'd0);
        do_pair(12'd1000, 12'd2048);
        do_pair(12'd1000, 12'd2048);
        expect_publish("keep_pairs", 12'd1000, 12'd2048, 4'b0010);

        // 5: eoc during WAIT_Y is held; a second one is dropped
        pulse_eoc();
        serve(AX, 12'd3000, 2);
        chk("t5_y_den", 32'(drp_den), 32'd1);
        step();
        pulse_eoc();
        step();
        pulse_eoc();
        drp_do   = {12'd1000, 4'h0};
        drp_drdy = 1'b1;
        step();
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        chk("t5_idle", 32'(dbg_state), 32'd0);
        chk("t5_no_den_in_idle", 32'(drp_den), 32'd0);
        step();
        chk("t5_pending_den", 32'(drp_den), 32'd1);
        chk("t5_pending_addr", 32'(drp_daddr), 32'(AX));
        serve(AX, 12'd3000, 1);
        serve(AY, 12'd1000, 1);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (drp_den !== 1'b0) flag = 1'b1;
        end
        chk("t5_extra_eoc_dropped", 32'(flag), 32'd0);
        do_pair(12'd3000, 12'd1000);
        do_pair(12'd3000, 12'd1000);
        expect_publish("pending", 12'd3000, 12'd1000, 4'b0101);

        // 6: enable dropped in WAIT_X after three pairs
        for (int i = 0; i < 3; i++) do_pair(12'd4000, 12'd4000);
        pulse_eoc();
        chk("t6_x_den", 32'(drp_den), 32'd1);
        step();
        enable = 1'b0;
        step();
        step();
        drp_do   = {12'd4000, 4'h0};
        drp_drdy = 1'b1;
        step();
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (drp_den !== 1'b0 || sample_valid !== 1'b0) flag = 1'b1;
            step();
        end
        chk("t6_no_publish", 32'(flag), 32'd0);
        chk("t6_idle", 32'(dbg_state), 32'd0);
        chk("t6_outputs_kept", 32'(joy_x), 32'd3000);
        enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) do_pair(12'd1000, 12'd3000);
        expect_publish("reenable", 12'd1000, 12'd3000, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
